// File: rtl/alu_muldiv_if.sv
// Operand/result bundle between the execute-stage controller (master) and alu_muldiv (slave).
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [4:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic             lessSigned;
    logic             lessUnsigned;
    logic             valid_out;
    logic             busy;

    modport master (
        output valid_in, op1, op2, alu_ctrl,
        input  ready_out, alu_result, zero, lessSigned, lessUnsigned, valid_out, busy
    );

    modport slave (
        input  valid_in, op1, op2, alu_ctrl,
        output ready_out, alu_result, zero, lessSigned, lessUnsigned, valid_out, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// RV32I ALU with one-cycle base ops and bit-serial RV32M multiply/divide/remainder.
// Iterative ops hold ready_out low for WIDTH cycles; divide-by-zero and signed overflow bypass iteration.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);
    localparam int               CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_result;
    logic               r_less_s, r_less_u;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_prod;
    logic [2:0]         r_mop;
    logic               r_neg;

    logic               w_ready, w_accept, w_is_m, w_fast, w_last;
    logic [2:0]         w_mop;
    logic               w_s1, w_s2, w_neg1, w_neg2, w_neg_res, w_div0, w_ovf;
    logic               w_lt_s, w_lt_u;
    logic [CW-1:0]      w_shamt;
    logic [WIDTH-1:0]   w_mag1, w_mag2, w_base_res, w_fast_res, w_m_res;
    logic [WIDTH:0]     w_sum, w_rem_sh, w_trial;
    logic [2*WIDTH-1:0] w_prod_next, w_prod_fix;

    assign w_ready  = (r_state != S_ITER);
    assign w_accept = bus.valid_in && w_ready;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_is_m   = bus.alu_ctrl[4];
    assign w_mop    = bus.alu_ctrl[2:0];
    assign w_shamt  = bus.op2[CW-1:0];
    assign w_lt_s   = $signed(bus.op1) < $signed(bus.op2);
    assign w_lt_u   = bus.op1 < bus.op2;

    // Operand signedness: DIV/REM signed, DIVU/REMU unsigned; MULHSU treats only op1 as signed.
    assign w_s1      = w_mop[2] ? ~w_mop[0] : (w_mop[1:0] != 2'b11);
    assign w_s2      = w_mop[2] ? ~w_mop[0] : ~w_mop[1];
    assign w_neg1    = w_s1 & bus.op1[WIDTH-1];
    assign w_neg2    = w_s2 & bus.op2[WIDTH-1];
    assign w_mag1    = w_neg1 ? -bus.op1 : bus.op1;
    assign w_mag2    = w_neg2 ? -bus.op2 : bus.op2;
    assign w_neg_res = (w_mop[2] && w_mop[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

    assign w_div0     = (bus.op2 == '0);
    assign w_ovf      = ~w_mop[0] && (bus.op1 == MIN_NEG) && (bus.op2 == '1);
    assign w_fast     = w_is_m && w_mop[2] && (w_div0 || w_ovf);
    assign w_fast_res = w_div0 ? (w_mop[1] ? bus.op1 : '1) : (w_mop[1] ? '0 : bus.op1);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_base_res = '0;
        case (bus.alu_ctrl[3:0])
            4'b0000: w_base_res = bus.op1 + bus.op2;
            4'b1000: w_base_res = bus.op1 - bus.op2;
            4'b0111: w_base_res = bus.op1 & bus.op2;
            4'b0110: w_base_res = bus.op1 | bus.op2;
            4'b0100: w_base_res = bus.op1 ^ bus.op2;
            4'b0001: w_base_res = bus.op1 << w_shamt;
            4'b0101: w_base_res = bus.op1 >> w_shamt;
            4'b1101: w_base_res = $signed(bus.op1) >>> w_shamt;
            4'b0010: w_base_res = {{(WIDTH-1){1'b0}}, w_lt_s};
            4'b0011: w_base_res = {{(WIDTH-1){1'b0}}, w_lt_u};
            default: w_base_res = '0;
        endcase
    end

    // One step: shift-add multiply on {acc, multiplier}, or restoring divide on {rem, quotient}.
    always_comb begin
        w_sum       = '0;
        w_rem_sh    = '0;
        w_trial     = '0;
        w_prod_next = r_prod;
        if (!r_mop[2]) begin
            w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
            w_prod_next = {w_sum, r_prod[WIDTH-1:1]};
        end else begin
            w_rem_sh    = r_prod[2*WIDTH-1:WIDTH-1];
            w_trial     = w_rem_sh - {1'b0, r_a};
            w_prod_next = {(w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                           r_prod[WIDTH-2:0], ~w_trial[WIDTH]};
        end
    end

    assign w_prod_fix = r_neg ? -w_prod_next : w_prod_next;

    always_comb begin
        w_m_res = '0;
        case (r_mop)
            3'b000:                 w_m_res = w_prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_m_res = w_prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_m_res = r_neg ? -w_prod_next[WIDTH-1:0] : w_prod_next[WIDTH-1:0];
            default:                w_m_res = r_neg ? -w_prod_next[2*WIDTH-1:WIDTH] : w_prod_next[2*WIDTH-1:WIDTH];
        endcase
    end

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_ITER:  w_state_next = w_last ? S_DONE : S_ITER;
            default: if (w_accept) w_state_next = (w_is_m && !w_fast) ? S_ITER : S_DONE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_less_s <= 1'b0;
            r_less_u <= 1'b0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_prod   <= '0;
            r_mop    <= '0;
            r_neg    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_less_s <= w_lt_s;
                r_less_u <= w_lt_u;
                r_cnt    <= '0;
                r_mop    <= w_mop;
                r_neg    <= w_neg_res;
                r_a      <= w_mop[2] ? w_mag2 : w_mag1;
                r_prod   <= {{WIDTH{1'b0}}, (w_mop[2] ? w_mag1 : w_mag2)};
                if (!w_is_m)
                    r_result <= w_base_res;
                else if (w_fast)
                    r_result <= w_fast_res;
            end else if (r_state == S_ITER) begin
                r_cnt  <= r_cnt + 1'b1;
                r_prod <= w_prod_next;
                if (w_last)
                    r_result <= w_m_res;
            end
        end
    end

    assign bus.ready_out    = w_ready;
    assign bus.busy         = (r_state == S_ITER);
    assign bus.valid_out    = (r_state == S_DONE);
    assign bus.alu_result   = r_result;
    assign bus.zero         = (r_result == '0);
    assign bus.lessSigned   = r_less_s;
    assign bus.lessUnsigned = r_less_u;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed cases plus random ops against an arithmetic reference model.
module tb_alu_muldiv;
    localparam int         W     = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b01000;
    localparam logic [4:0] OP_SLT   = 5'b00010;
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULH  = 5'b10001;
    localparam logic [4:0] OP_MULHU = 5'b10011;
    localparam logic [4:0] OP_DIV   = 5'b10100;
    localparam logic [4:0] OP_DIVU  = 5'b10101;
    localparam logic [4:0] OP_REM   = 5'b10110;
    localparam logic [4:0] OP_REMU  = 5'b10111;

    localparam logic [3:0] BASE_CODES [11] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                                               4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011, 4'b1111};

    typedef struct {
        logic [W-1:0] res;
        logic         ls;
        logic         lu;
        int           due;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    alu_muldiv_if #(.WIDTH(W)) bus();
    alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain RISC-V arithmetic on 64-bit integers.
    function automatic logic [W-1:0] model(input logic [4:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        if (!ctrl[4]) begin
            case (ctrl[3:0])
                4'b0000: return a + b;
                4'b1000: return a - b;
                4'b0111: return a & b;
                4'b0110: return a | b;
                4'b0100: return a ^ b;
                4'b0001: return a << b[4:0];
                4'b0101: return a >> b[4:0];
                4'b1101: return $signed(a) >>> b[4:0];
                4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
                4'b0011: return (a < b) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        end
        case (ctrl[2:0])
            3'b000:  begin p = sa * sb; return p[31:0]; end
            3'b001:  begin p = sa * sb; return p[63:32]; end
            3'b010:  begin p = sa * ub; return p[63:32]; end
            3'b011:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100:  begin
                if (b == 0) return '1;
                if (a == MINV && b == '1) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101:  return (b == 0) ? '1 : a / b;
            3'b110:  begin
                if (b == 0) return a;
                if (a == MINV && b == '1) return '0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_iterative(input logic [4:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
        if (!ctrl[4]) return 1'b0;
        if (ctrl[2] && (b == 0 || (!ctrl[0] && a == MINV && b == '1))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return '1;
            3:       return MINV;
            4:       return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rand_ctrl();
        if ($urandom_range(0, 1) == 0) return {1'b0, BASE_CODES[$urandom_range(0, 10)]};
        return {1'b1, 4'($urandom_range(0, 15))};
    endfunction

    // Called at a negedge; waits for ready, presents the op for one edge, records the expectation.
    task automatic issue(input logic [4:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
        int   guard;
        exp_t e;
        guard = 0;
        while (!bus.ready_out && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ready_out) check("ready_timeout", 64'(bus.ready_out), 64'd1);
        bus.valid_in = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.op1      = a;
        bus.op2      = b;
        if (track) begin
            e.res = model(ctrl, a, b);
            e.ls  = ($signed(a) < $signed(b));
            e.lu  = (a < b);
            e.due = cyc + 1 + (is_iterative(ctrl, a, b) ? W : 0);
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: every valid_out must match the oldest outstanding expectation, on its due cycle.
    always @(negedge clk) begin
        if (bus.valid_out) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid_out", 64'(bus.valid_out), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("alu_result", 64'(bus.alu_result), 64'(mon_e.res));
                check("zero", 64'(bus.zero), 64'(mon_e.res == '0));
                check("lessSigned", 64'(bus.lessSigned), 64'(mon_e.ls));
                check("lessUnsigned", 64'(bus.lessUnsigned), 64'(mon_e.lu));
                check("latency_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    initial begin
        int bcnt, rdy_busy, guard;
        bus.valid_in = 1'b0;
        bus.alu_ctrl = '0;
        bus.op1      = '0;
        bus.op2      = '0;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_alu_result", 64'(bus.alu_result), 64'd0);
        check("reset_zero", 64'(bus.zero), 64'd1);
        check("reset_valid_out", 64'(bus.valid_out), 64'd0);
        check("reset_ready_out", 64'(bus.ready_out), 64'd1);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_flags", {62'd0, bus.lessSigned, bus.lessUnsigned}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(OP_ADD, 32'd5, 32'd3, 1'b1);
        issue(OP_SUB, 32'd5, 32'd5, 1'b1);

        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1);
        bcnt = 0; rdy_busy = 0; guard = 0;
        while (!bus.valid_out && guard < 100) begin
            if (bus.busy) bcnt++;
            if (bus.busy && bus.ready_out) rdy_busy++;
            @(negedge clk);
            guard++;
        end
        check("mul_busy_cycles", 64'(bcnt), 64'd32);
        check("ready_low_while_busy", 64'(rdy_busy), 64'd0);

        issue(OP_MULH, MINV, MINV, 1'b1);
        issue(OP_MULHU, '1, '1, 1'b1);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        issue(OP_REMU, 32'd100, 32'd7, 1'b1);
        issue(OP_DIVU, 32'd5, 32'd0, 1'b1);
        issue(OP_REM, 32'd5, 32'd0, 1'b1);
        issue(OP_DIV, MINV, '1, 1'b1);
        issue(OP_REM, MINV, '1, 1'b1);
        issue(OP_SLT, '1, 32'd1, 1'b1);
        drain();

        // Abort an in-flight divide with reset.
        issue(OP_DIV, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid_out", 64'(bus.valid_out), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_ready_out", 64'(bus.ready_out), 64'd1);
        check("abort_alu_result", 64'(bus.alu_result), 64'd0);
        reset = 1'b0;
        issue(OP_ADD, 32'd1, 32'd1, 1'b1);
        drain();

        // valid_in pulses during ITER must be dropped.
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b1);
        guard = 0; rdy_busy = 0;
        while (bus.busy && guard < 100) begin
            if (bus.ready_out) rdy_busy++;
            bus.valid_in = 1'b1;
            bus.alu_ctrl = OP_ADD;
            bus.op1      = $urandom;
            bus.op2      = $urandom;
            @(negedge clk);
            guard++;
        end
        bus.valid_in = 1'b0;
        check("ignored_ready_low", 64'(rdy_busy), 64'd0);
        drain();

        for (int i = 0; i < 300; i++) begin
            issue(rand_ctrl(), rand_val(), rand_val(), 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
